core_nios2_gen2_0_cpu_debug_ocimem_arbiter: RTL and testbench
=============================================================

// Module: core_nios2_gen2_0_cpu_debug_ocimem_arbiter
// PURPOSE
//  Arbitrates one single-ported OCI debug memory between two requesters: the JTAG
//  debug slave (sysclk-side take_action strobes + jdo) and the Avalon debug_mem slave.
//  JTAG strobes are single-cycle and cannot stall, so they are held in a small command queue.
//  Sits between the debug slave wrapper's sysclk outputs and the OCI RAM / MonDReg logic.
// PARAMETERS
//  ADDR_W    8   word address width of the OCI memory
//  DATA_W    32  data width
//  JQ_DEPTH  2   JTAG command queue depth in entries; power of 2, >=2
// PORTS
//  clk                     in   1        system clock; all logic on rising edge
//  reset                   in   1        synchronous, active-high reset
//  jdo                     in   38       JTAG data-out bus, sampled on strobe cycles
//  take_action_ocimem_a    in   1        load JTAG address register from jdo[ADDR_W+16:17]
//  take_action_ocimem_b    in   1        enqueue write of jdo[34:3] at JTAG address, then addr+1
//  take_no_action_ocimem_a in   1        enqueue read at JTAG address, then addr+1
//  av_read                 in   1        Avalon read request
//  av_write                in   1        Avalon write request
//  av_address              in   ADDR_W   Avalon word address
//  av_writedata            in   DATA_W   Avalon write data
//  av_waitrequest          out  1        Avalon stall
//  av_readdata             out  DATA_W   Avalon read data, valid when read completes
//  mem_en                  out  1        memory access strobe, registered
//  mem_we                  out  1        1 = write, registered
//  mem_addr                out  ADDR_W   memory address, registered
//  mem_wdata               out  DATA_W   memory write data, registered
//  mem_rdata               in   DATA_W   memory read data, valid 1 cycle after mem_en
//  MonDReg                 out  DATA_W   last JTAG read result
//  monitor_ready           out  1        1-cycle pulse: MonDReg updated
//  jq_overflow             out  1        sticky: JTAG strobe dropped because queue was full
// BEHAVIOUR
//  Reset: state=IDLE, queue empty, JTAG addr=0, mem_en/mem_we=0, mem_addr/mem_wdata=0,
//   MonDReg=0, monitor_ready=0, jq_overflow=0, last_grant=AVALON.
//   Reset mid-access aborts it; in-flight read data is discarded and the queue is flushed.
//  Queue entry = {wr, addr, data}. addr is snapshotted at enqueue time.
//   JTAG addr increments mod 2^ADDR_W after each enqueue; 2^ADDR_W-1 wraps to 0.
//  Strobe on a full queue: entry dropped, addr not incremented, jq_overflow<=1.
//   jq_overflow clears on take_action_ocimem_a or reset.
//  Simultaneous strobes: priority ocimem_a > ocimem_b > no_action_ocimem_a; lower ones ignored.
//   Dequeue and enqueue in the same cycle are legal when the queue is full.
//  FSM states:
//   IDLE: requests are JTAG = queue non-empty and AV = av_read|av_write.
//    One requester pending: grant it. Both pending: grant the one != last_grant (round-robin).
//    On grant: register mem_en=1 with we/addr/wdata, update last_grant, pop the queue if
//    JTAG was granted, go to ISSUE.
//   ISSUE (mem_en=1): write -> IDLE; read -> RDATA. Avalon write completes here.
//   RDATA (mem_en=0): Avalon read: av_readdata=mem_rdata, completes this cycle.
//    JTAG read: MonDReg<=mem_rdata, monitor_ready=1 next cycle. Then -> IDLE.
//  mem_en is high exactly one cycle per access. Minimum spacing: write 2 cycles, read 3.
//  av_waitrequest = (av_read|av_write) & ~(Avalon grant completing this cycle).
//   Combinational, so it is high in the request cycle. Avalon inputs stay stable until completion.
//  Latency, request to completion: Avalon write 2 cycles, Avalon read 3 cycles
//   (uncontended, starting from IDLE).
// TESTING
//  1. ocimem_a with addr 0x10, then ocimem_b with data 0xDEADBEEF -> mem_en,we=1,addr=0x10,
//     wdata=0xDEADBEEF 2 cycles after the strobe; JTAG addr=0x11.
//  2. Avalon read 0x05, mem_rdata=0x12345678 -> waitrequest low on cycle 3 with
//     readdata=0x12345678.
//  3. JTAG read and Avalon write pending in the same cycle after reset -> JTAG served first
//     (last_grant=AVALON), Avalon second; alternates on repeat.
//  4. Three back-to-back JTAG writes at addr 0xFF with the queue blocked by an Avalon read
//     -> 2 queued (0xFF, 0x00), third dropped, jq_overflow=1.
//  5. JTAG read of 0x20 -> MonDReg=mem_rdata and a single monitor_ready pulse 4 cycles
//     after the strobe.
//  6. Assert reset in RDATA with 2 queued -> next cycle: IDLE, queue empty, mem_en=0,
//     no monitor_ready.

Source files
------------

// File: rtl/core_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Shares the single-ported OCI debug memory between queued JTAG debug commands
// and the Avalon debug_mem slave, with round-robin arbitration when both are waiting.
module core_nios2_gen2_0_cpu_debug_ocimem_arbiter #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned JQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [ADDR_W-1:0] av_address,
   input  logic [DATA_W-1:0] av_writedata,
   output logic              av_waitrequest,
   output logic [DATA_W-1:0] av_readdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              jq_overflow
);

   localparam int unsigned PTR_W = (JQ_DEPTH > 1) ? $clog2(JQ_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RDATA = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_JTAG = 1'b0,
      OWNER_AV   = 1'b1
   } owner_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } jq_entry_t;

   state_t            state;
   state_t            state_nxt;
   owner_t            last_grant;

   jq_entry_t         jq_mem [JQ_DEPTH];
   logic [PTR_W:0]    jq_wr_ptr;
   logic [PTR_W:0]    jq_rd_ptr;
   logic              jq_empty;
   logic              jq_full;
   jq_entry_t         jq_head;
   logic [ADDR_W-1:0] jtag_addr;

   logic              cmd_wr_c;
   logic              cmd_rd_c;
   logic              push_req_c;
   logic              push_c;
   logic              drop_c;
   jq_entry_t         push_entry_c;

   logic              jtag_req_c;
   logic              av_req_c;
   logic              grant_jtag_c;
   logic              grant_av_c;
   logic              av_done_c;
   logic              mon_load_c;

   // jdo bits outside the address and data fields carry other debug commands
   logic              unused_jdo_bits;
   assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

   // ---------------------------------------------------------------- queue
   assign jq_empty = (jq_wr_ptr == jq_rd_ptr);
   assign jq_full  = (jq_wr_ptr[PTR_W] != jq_rd_ptr[PTR_W]) &&
                     (jq_wr_ptr[PTR_W-1:0] == jq_rd_ptr[PTR_W-1:0]);
   assign jq_head  = jq_mem[jq_rd_ptr[PTR_W-1:0]];

   // Strobe decode: ocimem_a beats ocimem_b beats no_action; a pop frees a full slot
   always_comb begin
      cmd_wr_c          = ~take_action_ocimem_a & take_action_ocimem_b;
      cmd_rd_c          = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
      push_req_c        = cmd_wr_c | cmd_rd_c;
      push_c            = push_req_c & (~jq_full | grant_jtag_c);
      drop_c            = push_req_c & ~push_c;
      push_entry_c      = '0;
      push_entry_c.wr   = cmd_wr_c;
      push_entry_c.addr = jtag_addr;
      if (cmd_wr_c) begin
         push_entry_c.data = DATA_W'(jdo[34:3]);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         jq_mem[jq_wr_ptr[PTR_W-1:0]] <= push_entry_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         jq_wr_ptr   <= '0;
         jq_rd_ptr   <= '0;
         jtag_addr   <= '0;
         jq_overflow <= 1'b0;
      end else begin
         if (push_c) begin
            jq_wr_ptr <= jq_wr_ptr + (PTR_W+1)'(1);
         end
         if (grant_jtag_c) begin
            jq_rd_ptr <= jq_rd_ptr + (PTR_W+1)'(1);
         end
         if (take_action_ocimem_a) begin
            jtag_addr   <= jdo[ADDR_W+16:17];
            jq_overflow <= 1'b0;
         end else begin
            if (push_c) begin
               jtag_addr <= jtag_addr + ADDR_W'(1);
            end
            if (drop_c) begin
               jq_overflow <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_jtag_c || grant_av_c) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = mem_we ? S_IDLE : S_RDATA;
         S_RDATA: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant and completion decode; last_grant names the owner of the access in flight
   always_comb begin
      jtag_req_c   = ~jq_empty;
      av_req_c     = av_read | av_write;
      grant_jtag_c = 1'b0;
      grant_av_c   = 1'b0;
      av_done_c    = 1'b0;
      mon_load_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (jtag_req_c && (!av_req_c || last_grant == OWNER_AV)) begin
               grant_jtag_c = 1'b1;
            end else if (av_req_c) begin
               grant_av_c = 1'b1;
            end
         end
         S_ISSUE: begin
            av_done_c = (last_grant == OWNER_AV) && mem_we;
         end
         S_RDATA: begin
            av_done_c  = (last_grant == OWNER_AV);
            mon_load_c = (last_grant == OWNER_JTAG);
         end
         default: begin
            av_done_c = 1'b0;
         end
      endcase
   end

   assign av_waitrequest = av_req_c & ~av_done_c;
   assign av_readdata    = (state == S_RDATA && last_grant == OWNER_AV) ? mem_rdata : '0;

   // ---------------------------------------------------------------- memory port
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         last_grant    <= OWNER_AV;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
      end else begin
         mem_en        <= grant_jtag_c | grant_av_c;
         monitor_ready <= mon_load_c;
         if (mon_load_c) begin
            MonDReg <= mem_rdata;
         end
         if (grant_jtag_c) begin
            mem_we     <= jq_head.wr;
            mem_addr   <= jq_head.addr;
            mem_wdata  <= jq_head.data;
            last_grant <= OWNER_JTAG;
         end else if (grant_av_c) begin
            mem_we     <= av_write;
            mem_addr   <= av_address;
            mem_wdata  <= av_writedata;
            last_grant <= OWNER_AV;
         end else begin
            mem_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_core_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Directed bench for the OCI memory arbiter: a per-cycle vector table followed by
// hand-written sequences for queue overflow and reset during a read.
module tb_core_nios2_gen2_0_cpu_debug_ocimem_arbiter;

   logic        clk;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        take_no_action_ocimem_a;
   logic        av_read;
   logic        av_write;
   logic [7:0]  av_address;
   logic [31:0] av_writedata;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        jq_overflow;

   int errors = 0;
   int checks = 0;

   core_nios2_gen2_0_cpu_debug_ocimem_arbiter dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .av_read                 (av_read),
      .av_write                (av_write),
      .av_address              (av_address),
      .av_writedata            (av_writedata),
      .av_waitrequest          (av_waitrequest),
      .av_readdata             (av_readdata),
      .mem_en                  (mem_en),
      .mem_we                  (mem_we),
      .mem_addr                (mem_addr),
      .mem_wdata               (mem_wdata),
      .mem_rdata               (mem_rdata),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .jq_overflow             (jq_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish by %0t", $time);
      $fatal(1, "timeout");
   end

   // One record per clock: inputs for the cycle and outputs expected mid-cycle
   typedef struct {
      logic        rst, sa, sb, sn;
      logic [37:0] j;
      logic        rd, wr;
      logic [7:0]  aa;
      logic [31:0] awd;
      logic [31:0] mrd;
      logic        e_en, e_we;
      logic [7:0]  e_addr;
      logic [31:0] e_wd;
      logic        e_wait, e_mrdy, e_ovf, c_rdd;
      logic [31:0] e_rdd;
      logic [31:0] e_mon;
   } vec_t;

   localparam logic [3:0] NOP = 4'b0000, RST = 4'b1000, SA = 4'b0100, SB = 4'b0010, SN = 4'b0001;
   localparam logic [1:0] AVN = 2'b00, RD = 2'b10, WR = 2'b01;
   localparam logic [1:0] EN0 = 2'b00, EN_R = 2'b10, EN_W = 2'b11;
   localparam logic [3:0] F0 = 4'b0000, FW = 4'b1000, FM = 4'b0100, FR = 4'b0001;

   function automatic logic [37:0] ja(input logic [7:0] a);
      return 38'(a) << 17;
   endfunction

   function automatic logic [37:0] jd(input logic [31:0] d);
      return 38'(d) << 3;
   endfunction

   function automatic vec_t s(input logic [3:0] ctl, input logic [37:0] j, input logic [1:0] av,
                              input logic [7:0] aa, input logic [31:0] awd, input logic [31:0] mrd);
      vec_t t;
      t.rst = ctl[3]; t.sa = ctl[2]; t.sb = ctl[1]; t.sn = ctl[0];
      t.j = j; t.rd = av[1]; t.wr = av[0]; t.aa = aa; t.awd = awd; t.mrd = mrd;
      t.e_en = 1'b0; t.e_we = 1'b0; t.e_addr = '0; t.e_wd = '0;
      t.e_wait = 1'b0; t.e_mrdy = 1'b0; t.e_ovf = 1'b0; t.c_rdd = 1'b0;
      t.e_rdd = '0; t.e_mon = '0;
      return t;
   endfunction

   function automatic vec_t v(input logic [3:0] ctl, input logic [37:0] j, input logic [1:0] av,
                              input logic [7:0] aa, input logic [31:0] awd, input logic [31:0] mrd,
                              input logic [1:0] een, input logic [7:0] ea, input logic [31:0] ewd,
                              input logic [3:0] flg, input logic [31:0] erdd, input logic [31:0] emon);
      vec_t t;
      t = s(ctl, j, av, aa, awd, mrd);
      t.e_en = een[1]; t.e_we = een[0]; t.e_addr = ea; t.e_wd = ewd;
      t.e_wait = flg[3]; t.e_mrdy = flg[2]; t.e_ovf = flg[1]; t.c_rdd = flg[0];
      t.e_rdd = erdd; t.e_mon = emon;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      reset = t.rst;
      take_action_ocimem_a = t.sa;
      take_action_ocimem_b = t.sb;
      take_no_action_ocimem_a = t.sn;
      jdo = t.j;
      av_read = t.rd;
      av_write = t.wr;
      av_address = t.aa;
      av_writedata = t.awd;
      mem_rdata = t.mrd;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop_cycle(input logic [3:0] ctl, input logic [37:0] j);
      apply(s(ctl, j, AVN, '0, '0, '0));
      @(negedge clk);
   endtask

   task automatic check_vec(input int i, input vec_t t);
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(t.e_en));
      chk($sformatf("v%0d waitrequest", i), 32'(av_waitrequest), 32'(t.e_wait));
      chk($sformatf("v%0d monitor_ready", i), 32'(monitor_ready), 32'(t.e_mrdy));
      chk($sformatf("v%0d jq_overflow", i), 32'(jq_overflow), 32'(t.e_ovf));
      chk($sformatf("v%0d MonDReg", i), MonDReg, t.e_mon);
      if (t.e_en) begin
         chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(t.e_we));
         chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(t.e_addr));
         if (t.e_we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, t.e_wd);
      end
      if (t.c_rdd) chk($sformatf("v%0d readdata", i), av_readdata, t.e_rdd);
   endtask

   vec_t tbl[$];

   initial begin
      apply(s(RST, '0, AVN, '0, '0, '0));
      repeat (2) @(posedge clk);
      #1;

      // reset state, then JTAG write at 0x10 and a follow-up read proving addr advanced to 0x11
      tbl.push_back(v(RST, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(SA, ja(8'h10), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(SB, jd(32'hDEADBEEF), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN_W, 8'h10, 32'hDEADBEEF, F0, '0, '0));
      tbl.push_back(v(SN, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN_R, 8'h11, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, 32'hCAFEF00D, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, FM, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      // Avalon read (3 cycles) and write (2 cycles)
      tbl.push_back(v(NOP, '0, RD, 8'h05, '0, '0, EN0, '0, '0, FW, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, RD, 8'h05, '0, '0, EN_R, 8'h05, '0, FW, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, RD, 8'h05, '0, 32'h12345678, EN0, '0, '0, FR, 32'h12345678, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, WR, 8'h33, 32'hA5A50001, '0, EN0, '0, '0, FW, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, WR, 8'h33, 32'hA5A50001, '0, EN_W, 8'h33, 32'hA5A50001, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      // JTAG read of 0x20: monitor_ready four cycles after the strobe
      tbl.push_back(v(SA, ja(8'h20), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(SN, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN_R, 8'h20, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, 32'h0BADF00D, EN0, '0, '0, F0, '0, 32'hCAFEF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, FM, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      // strobe priority: a beats b and no_action, b beats no_action
      tbl.push_back(v(SA | SB | SN, ja(8'h40), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(SB, jd(32'h77), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN_W, 8'h40, 32'h77, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(SB | SN, jd(32'h55), AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN_W, 8'h41, 32'h55, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      // reset, then contention: JTAG first after reset, then strict alternation
      tbl.push_back(v(RST, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'h0BADF00D));
      tbl.push_back(v(SN, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, '0));
      tbl.push_back(v(SN, '0, WR, 8'h70, 32'h1, '0, EN0, '0, '0, FW, '0, '0));
      tbl.push_back(v(NOP, '0, WR, 8'h70, 32'h1, '0, EN_R, 8'h00, '0, FW, '0, '0));
      tbl.push_back(v(NOP, '0, WR, 8'h70, 32'h1, 32'hAAAA, EN0, '0, '0, FW, '0, '0));
      tbl.push_back(v(NOP, '0, WR, 8'h70, 32'h1, '0, EN0, '0, '0, FW | FM, '0, 32'hAAAA));
      tbl.push_back(v(NOP, '0, WR, 8'h70, 32'h1, '0, EN_W, 8'h70, 32'h1, F0, '0, 32'hAAAA));
      tbl.push_back(v(NOP, '0, WR, 8'h71, 32'h2, '0, EN0, '0, '0, FW, '0, 32'hAAAA));
      tbl.push_back(v(NOP, '0, WR, 8'h71, 32'h2, '0, EN_R, 8'h01, '0, FW, '0, 32'hAAAA));
      tbl.push_back(v(NOP, '0, WR, 8'h71, 32'h2, 32'hBBBB, EN0, '0, '0, FW, '0, 32'hAAAA));
      tbl.push_back(v(NOP, '0, WR, 8'h71, 32'h2, '0, EN0, '0, '0, FW | FM, '0, 32'hBBBB));
      tbl.push_back(v(NOP, '0, WR, 8'h71, 32'h2, '0, EN_W, 8'h71, 32'h2, F0, '0, 32'hBBBB));
      tbl.push_back(v(NOP, '0, AVN, '0, '0, '0, EN0, '0, '0, F0, '0, 32'hBBBB));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         @(negedge clk);
         check_vec(i, tbl[i]);
         step();
      end

      // queue held off by an Avalon read: writes at 0xFF and 0x00 queue, third dropped
      nop_cycle(SA, ja(8'hFF));
      chk("ovf load en", 32'(mem_en), 32'd0);
      step();
      apply(s(SB, jd(32'h100), RD, 8'h09, '0, '0)); @(negedge clk);
      chk("ovf av wait", 32'(av_waitrequest), 32'd1);
      step();
      apply(s(SB, jd(32'h101), RD, 8'h09, '0, '0)); @(negedge clk);
      chk("ovf av issue en", 32'(mem_en), 32'd1);
      chk("ovf av issue addr", 32'(mem_addr), 32'h09);
      step();
      apply(s(SB, jd(32'h102), RD, 8'h09, '0, 32'h99)); @(negedge clk);
      chk("ovf av done wait", 32'(av_waitrequest), 32'd0);
      chk("ovf av readdata", av_readdata, 32'h99);
      chk("ovf flag before drop", 32'(jq_overflow), 32'd0);
      step();
      nop_cycle(NOP, '0);
      chk("ovf flag set", 32'(jq_overflow), 32'd1);
      chk("ovf grant gap", 32'(mem_en), 32'd0);
      step();
      nop_cycle(NOP, '0);
      chk("ovf q0 en", 32'(mem_en), 32'd1);
      chk("ovf q0 addr", 32'(mem_addr), 32'hFF);
      chk("ovf q0 wdata", mem_wdata, 32'h100);
      step();
      nop_cycle(NOP, '0);
      chk("ovf q0 gap", 32'(mem_en), 32'd0);
      step();
      nop_cycle(NOP, '0);
      chk("ovf q1 en", 32'(mem_en), 32'd1);
      chk("ovf q1 addr wrap", 32'(mem_addr), 32'h00);
      chk("ovf q1 wdata", mem_wdata, 32'h101);
      step();
      nop_cycle(SB, jd(32'h103));
      chk("ovf sticky", 32'(jq_overflow), 32'd1);
      step();
      nop_cycle(NOP, '0);
      chk("ovf third dropped", 32'(mem_en), 32'd0);
      step();
      nop_cycle(NOP, '0);
      chk("ovf next en", 32'(mem_en), 32'd1);
      chk("ovf addr not advanced", 32'(mem_addr), 32'h01);
      chk("ovf next wdata", mem_wdata, 32'h103);
      step();
      nop_cycle(SA, ja(8'h00));
      chk("ovf before clear", 32'(jq_overflow), 32'd1);
      step();
      nop_cycle(NOP, '0);
      chk("ovf cleared by ocimem_a", 32'(jq_overflow), 32'd0);
      step();

      // reset in RDATA with two reads queued
      nop_cycle(SN, '0);
      chk("rst q fill en", 32'(mem_en), 32'd0);
      step();
      nop_cycle(SN, '0);
      chk("rst q grant en", 32'(mem_en), 32'd0);
      step();
      nop_cycle(SN, '0);
      chk("rst issue en", 32'(mem_en), 32'd1);
      chk("rst issue we", 32'(mem_we), 32'd0);
      chk("rst issue addr", 32'(mem_addr), 32'h00);
      step();
      apply(s(RST, '0, AVN, '0, '0, 32'hDEAD0001)); @(negedge clk);
      chk("rst rdata en", 32'(mem_en), 32'd0);
      step();
      nop_cycle(NOP, '0);
      chk("rst after en", 32'(mem_en), 32'd0);
      chk("rst no monitor_ready", 32'(monitor_ready), 32'd0);
      chk("rst MonDReg", MonDReg, 32'h0);
      chk("rst ovf", 32'(jq_overflow), 32'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         nop_cycle(NOP, '0);
         chk($sformatf("rst flushed en %0d", k), 32'(mem_en), 32'd0);
         chk($sformatf("rst flushed mrdy %0d", k), 32'(monitor_ready), 32'd0);
         step();
      end
      nop_cycle(SN, '0);
      step();
      nop_cycle(NOP, '0);
      step();
      nop_cycle(NOP, '0);
      chk("rst addr cleared en", 32'(mem_en), 32'd1);
      chk("rst addr cleared addr", 32'(mem_addr), 32'h00);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
